ast_width_narrower: RTL and testbench
=====================================

Name: ast_width_narrower

Overview:
- Avalon-ST width reducer; the downstream counterpart of ast_width_extender.
- Accepts wide beats of DATA_IN_W bits and re-emits each one as up to DATA_IN_W/DATA_OUT_W narrow beats of DATA_OUT_W bits.
- Preserves packet framing (sop/eop), channel and byte-level empty.
- Registered outputs; sustains one narrow beat per cycle while the sink is ready.

Parameters:
- DATA_IN_W, 64: input data width in bits; integer multiple of DATA_OUT_W.
- DATA_OUT_W, 16: output data width in bits; multiple of 8.
- CHANNEL_W, 10: channel width in bits.
- EMPTY_IN_W, $clog2(DATA_IN_W/8): input empty width (derived).
- EMPTY_OUT_W, max(1,$clog2(DATA_OUT_W/8)): output empty width (derived).

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  asynchronous reset, active-low
- ast_data_i  in  DATA_IN_W  input data; first symbol in the MSBs
- ast_startofpacket_i  in  1  input sop
- ast_endofpacket_i  in  1  input eop
- ast_valid_i  in  1  input valid
- ast_empty_i  in  EMPTY_IN_W  unused bytes in the LSBs; meaningful only with eop
- ast_channel_i  in  CHANNEL_W  input channel
- ast_ready_o  out  1  input ready
- ast_data_o  out  DATA_OUT_W  output data
- ast_startofpacket_o  out  1  output sop
- ast_endofpacket_o  out  1  output eop
- ast_valid_o  out  1  output valid
- ast_empty_o  out  EMPTY_OUT_W  output empty
- ast_channel_o  out  CHANNEL_W  output channel
- ast_ready_i  in  1  output ready

Behaviour:
- Constants:
  - RATIO = DATA_IN_W/DATA_OUT_W
  - BI = DATA_IN_W/8
  - BO = DATA_OUT_W/8
- Reset (arstn_i low, asynchronous):
  - FSM goes to IDLE; word counter cleared; beat register cleared.
  - All outputs 0, except ast_ready_o = 1.
  - Any partially emitted beat is discarded; nothing is replayed after reset.
- Handshakes:
  - Input transfer: ast_valid_i && ast_ready_o at a rising edge.
  - Output transfer: ast_valid_o && ast_ready_i at a rising edge.
  - ast_ready_o is combinational: ast_ready_o = IDLE || (last_word && ast_ready_i). No input-to-output combinational path otherwise.
  - While ast_valid_o && !ast_ready_i: data, sop, eop, empty and channel are held stable.
- FSM:
  - IDLE: ast_valid_o = 0. An input transfer loads the beat register, sets word_idx = 0 and computes nwords. Next state SEND.
  - SEND: ast_valid_o = 1 and ast_data_o = slice word_idx, counted from the MSB end.
    - Output transfer, not last_word: word_idx increments.
    - Output transfer, last_word, new input transfer in the same edge: load the new beat, stay in SEND (back-to-back, no bubble).
    - Output transfer, last_word, no new input: go to IDLE.
- Word count:
  - Non-eop beat: nwords = RATIO.
  - Eop beat: V = BI - ast_empty_i and nwords = ceil(V/BO).
  - V = 0 is illegal; ast_empty_i >= BI is clamped to BI-1.
  - last_word = (word_idx == nwords-1).
- Framing per output word:
  - ast_startofpacket_o = captured sop && word_idx == 0.
  - ast_endofpacket_o = captured eop && last_word.
  - ast_empty_o = nwords*BO - V on the eop word, 0 elsewhere.
  - ast_channel_o = captured channel on every word of the beat.
  - Single-beat packet (sop and eop together): both flags honoured; if nwords = 1, sop and eop appear on the same word.
- Timing:
  - Latency: input accepted at edge k → first narrow word valid after edge k.
  - Throughput: RATIO words per input beat; input ready once per beat.
- ast_empty_i on non-eop beats is ignored. Input protocol checking (sop/eop ordering) is out of scope.

Decomposition:
- Package usr_types_and_params holds:
  - the DATA_IN_W/DATA_OUT_W/CHANNEL_W defaults and the derived RATIO, BI, BO, EMPTY_*_W;
  - the state enum typedef (IDLE, SEND);
  - a packed struct typedef for the captured beat (data, sop, eop, empty, channel).
- Single module; no sub-module needed. The nwords/empty computation is a package function so that it can be shared by the testbench scoreboard.

Test Plan (DATA_IN_W=64, DATA_OUT_W=16, RATIO=4):
- Reset: hold arstn_i low → ast_valid_o=0, ast_ready_o=1, all other outputs 0. Release, then send one beat data=64'h1111_2222_3333_4444, sop=1, eop=1, empty=0, ready_i=1 → outputs 1111, 2222, 3333, 4444 on consecutive cycles; sop on word 0; eop and empty=0 on word 3; ast_ready_o high again on the last-word cycle.
- Partial last beat: 2-beat packet, second beat eop with empty=3 (V=5) → 3 words from that beat; the final word has eop=1, empty=1; total 7 narrow words.
- Back-to-back: 3 packets on channel 5, 7, 9 with valid_i held high → no idle cycle between beats; channel_o correct on every word.
- Backpressure: ast_ready_i toggled randomly → outputs stable while stalled; output sequence identical to the unstalled run; no loss or duplication.
- Reset mid-beat: assert arstn_i after word 1 of a beat → outputs cleared immediately. After release, the next packet begins cleanly with sop and no stale words.

Source files
------------

// File: rtl/ast_width_narrower_pkg.sv
// Shared types and parameters for the Avalon-ST width narrower.
// Also holds the word-count helpers used by the datapath.
package usr_types_and_params;

    localparam int DATA_IN_W   = 64;
    localparam int DATA_OUT_W  = 16;
    localparam int CHANNEL_W   = 10;
    localparam int RATIO       = DATA_IN_W / DATA_OUT_W;
    localparam int BI          = DATA_IN_W / 8;
    localparam int BO          = DATA_OUT_W / 8;
    localparam int EMPTY_IN_W  = $clog2(BI);
    localparam int EMPTY_OUT_W = ($clog2(BO) > 1) ? $clog2(BO) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    typedef struct packed {
        logic [DATA_IN_W-1:0]  data;
        logic                  sop;
        logic                  eop;
        logic [EMPTY_IN_W-1:0] empty;
        logic [CHANNEL_W-1:0]  channel;
    } beat_t;

    // Valid bytes of an eop beat; an empty of BI or more would leave
    // nothing, so it is clamped to keep at least one byte.
    function automatic int valid_bytes(input int empty, input int bi);
        int e;
        e = (empty >= bi) ? bi - 1 : empty;
        return bi - e;
    endfunction

    // Narrow words needed to carry one wide beat.
    function automatic int calc_nwords(input bit eop, input int empty,
                                       input int bi, input int bo,
                                       input int ratio);
        if (!eop) return ratio;
        return (valid_bytes(empty, bi) + bo - 1) / bo;
    endfunction

    // Unused bytes in the final narrow word of an eop beat.
    function automatic int calc_empty(input bit eop, input int empty,
                                      input int bi, input int bo,
                                      input int ratio);
        if (!eop) return 0;
        return calc_nwords(eop, empty, bi, bo, ratio) * bo
               - valid_bytes(empty, bi);
    endfunction

endpackage

// File: rtl/ast_width_narrower.sv
// Avalon-ST width narrower: splits each wide beat into narrow words,
// MSB first, keeping sop/eop, channel and byte empty intact.
import usr_types_and_params::*;

module ast_width_narrower #(
    parameter int DATA_IN_W   = usr_types_and_params::DATA_IN_W,
    parameter int DATA_OUT_W  = usr_types_and_params::DATA_OUT_W,
    parameter int CHANNEL_W   = usr_types_and_params::CHANNEL_W,
    parameter int EMPTY_IN_W  = $clog2(DATA_IN_W / 8),
    parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) > 1) ?
                                $clog2(DATA_OUT_W / 8) : 1
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int RAT  = DATA_IN_W / DATA_OUT_W;
    localparam int BIN  = DATA_IN_W / 8;
    localparam int BOUT = DATA_OUT_W / 8;
    localparam int CW   = $clog2(RAT + 1);

    state_e               state_q, state_d;
    beat_t                beat_q;
    logic [CW-1:0]        idx_q;
    logic [CW-1:0]        nwords_q;
    logic                 last_word;
    logic                 in_xfer;
    logic                 load;
    logic                 adv;
    logic                 send;
    logic [DATA_IN_W-1:0] data_sh;

    assign send      = (state_q == SEND);
    assign last_word = send && (idx_q == nwords_q - CW'(1));
    assign ast_ready_o = (state_q == IDLE) || (last_word && ast_ready_i);
    assign in_xfer   = ast_valid_i && ast_ready_o;

    // Next state plus load/advance strobes for the beat datapath.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ast_ready_i) begin
                    if (!last_word) begin
                        adv = 1'b1;
                    end else if (in_xfer) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat capture and word pointer; a reset drops any half-sent beat.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            beat_q   <= '0;
            idx_q    <= '0;
            nwords_q <= '0;
        end else if (load) begin
            beat_q.data    <= ast_data_i;
            beat_q.sop     <= ast_startofpacket_i;
            beat_q.eop     <= ast_endofpacket_i;
            beat_q.empty   <= ast_empty_i;
            beat_q.channel <= ast_channel_i;
            idx_q          <= '0;
            nwords_q       <= CW'(calc_nwords(ast_endofpacket_i,
                                              int'(ast_empty_i),
                                              BIN, BOUT, RAT));
        end else if (adv) begin
            idx_q <= idx_q + CW'(1);
        end
    end

    // Output word selection; everything is driven from registers.
    always_comb begin
        data_sh             = beat_q.data << (int'(idx_q) * DATA_OUT_W);
        ast_valid_o         = send;
        ast_data_o          = '0;
        ast_channel_o       = '0;
        ast_startofpacket_o = 1'b0;
        ast_endofpacket_o   = 1'b0;
        ast_empty_o         = '0;
        if (send) begin
            ast_data_o          = data_sh[DATA_IN_W-1 -: DATA_OUT_W];
            ast_channel_o       = beat_q.channel;
            ast_startofpacket_o = beat_q.sop && (idx_q == '0);
            ast_endofpacket_o   = beat_q.eop && last_word;
            if (beat_q.eop && last_word) begin
                ast_empty_o = EMPTY_OUT_W'(calc_empty(1'b1,
                                  int'(beat_q.empty), BIN, BOUT, RAT));
            end
        end
    end

endmodule

// File: tb/tb_ast_width_narrower.sv
// Scoreboard bench for ast_width_narrower: directed beats push
// hand-computed narrow words; a monitor pops and compares each transfer.
module tb_ast_width_narrower;
    import usr_types_and_params::*;

    logic                   clk = 1'b0;
    logic                   arstn_i;
    logic [DATA_IN_W-1:0]   ast_data_i;
    logic                   ast_startofpacket_i;
    logic                   ast_endofpacket_i;
    logic                   ast_valid_i;
    logic [EMPTY_IN_W-1:0]  ast_empty_i;
    logic [CHANNEL_W-1:0]   ast_channel_i;
    logic                   ast_ready_o;
    logic [DATA_OUT_W-1:0]  ast_data_o;
    logic                   ast_startofpacket_o;
    logic                   ast_endofpacket_o;
    logic                   ast_valid_o;
    logic [EMPTY_OUT_W-1:0] ast_empty_o;
    logic [CHANNEL_W-1:0]   ast_channel_o;
    logic                   ast_ready_i;

    always #5 clk = ~clk;

    ast_width_narrower dut (
        .clk_i               (clk),
        .arstn_i             (arstn_i),
        .ast_data_i          (ast_data_i),
        .ast_startofpacket_i (ast_startofpacket_i),
        .ast_endofpacket_i   (ast_endofpacket_i),
        .ast_valid_i         (ast_valid_i),
        .ast_empty_i         (ast_empty_i),
        .ast_channel_i       (ast_channel_i),
        .ast_ready_o         (ast_ready_o),
        .ast_data_o          (ast_data_o),
        .ast_startofpacket_o (ast_startofpacket_o),
        .ast_endofpacket_o   (ast_endofpacket_o),
        .ast_valid_o         (ast_valid_o),
        .ast_empty_o         (ast_empty_o),
        .ast_channel_o       (ast_channel_o),
        .ast_ready_i         (ast_ready_i)
    );

    typedef struct packed {
        logic [DATA_OUT_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [EMPTY_OUT_W-1:0] empty;
        logic [CHANNEL_W-1:0]   ch;
        logic                   last;
    } exp_t;

    localparam int AW = DATA_OUT_W + 2 + EMPTY_OUT_W + CHANNEL_W;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            xfers  = 0;
    bit            bp_en  = 1'b0;
    bit            b2b_en = 1'b0;
    bit            b2b_started = 1'b0;
    int            idle_cnt = 0;
    bit            hold_v = 1'b0;
    logic [AW:0]   held;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input bit s, input bit e,
                        input int emp, input int ch, input bit last);
        exp_t x;
        x.data  = d;
        x.sop   = s;
        x.eop   = e;
        x.empty = EMPTY_OUT_W'(emp);
        x.ch    = CHANNEL_W'(ch);
        x.last  = last;
        q.push_back(x);
    endtask

    function automatic logic [AW-1:0] out_vec();
        return {ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
                ast_empty_o, ast_channel_o};
    endfunction

    // Monitor: scoreboard pops, stall stability, bubble counting.
    always @(negedge clk) begin
        exp_t e;
        if (arstn_i) begin
            if (hold_v) begin
                chk("stall_hold", 64'({ast_valid_o, out_vec()}), 64'(held));
                hold_v = 1'b0;
            end
            if (ast_valid_o && !ast_ready_i) begin
                held   = {ast_valid_o, out_vec()};
                hold_v = 1'b1;
            end
            if (ast_valid_o && ast_ready_i) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 64'(out_vec()), 64'd0);
                    errors += (out_vec() == '0) ? 1 : 0;
                end else begin
                    e = q.pop_front();
                    chk("word", 64'(out_vec()),
                        64'({e.data, e.sop, e.eop, e.empty, e.ch}));
                    chk("ready_o_last", 64'(ast_ready_o), 64'(e.last));
                end
                xfers++;
            end
            if (b2b_en) begin
                if (ast_valid_o) b2b_started = 1'b1;
                else if (b2b_started && q.size() > 0) idle_cnt++;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    // Sink ready: random when backpressure is enabled.
    initial begin
        ast_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ast_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_beat(input logic [63:0] d, input bit s,
                             input bit e, input int emp, input int ch);
        bit acc;
        acc                 = 1'b0;
        ast_valid_i         = 1'b1;
        ast_data_i          = DATA_IN_W'(d);
        ast_startofpacket_i = s;
        ast_endofpacket_i   = e;
        ast_empty_i         = EMPTY_IN_W'(emp);
        ast_channel_i       = CHANNEL_W'(ch);
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = ast_ready_o;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle_in();
        ast_valid_i         = 1'b0;
        ast_startofpacket_i = 1'b0;
        ast_endofpacket_i   = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && q.size() > 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_valid"}, 64'(ast_valid_o), 64'd0);
        chk({nm, "_ready"}, 64'(ast_ready_o), 64'd1);
        chk({nm, "_outs"}, 64'(out_vec()), 64'd0);
    endtask

    task automatic pkt2();
        push(16'hAAAA, 1, 0, 0, 2, 0);
        push(16'hBBBB, 0, 0, 0, 2, 0);
        push(16'hCCCC, 0, 0, 0, 2, 0);
        push(16'hDDDD, 0, 0, 0, 2, 1);
        push(16'h0102, 0, 0, 0, 2, 0);
        push(16'h0304, 0, 0, 0, 2, 0);
        push(16'h0506, 0, 1, 1, 2, 1);
        send_beat(64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 5, 2);
        send_beat(64'h0102_0304_0506_0708, 0, 1, 3, 2);
        idle_in();
    endtask

    task automatic pkt3();
        logic [15:0] hi;
        int chs[3] = '{5, 7, 9};
        for (int p = 0; p < 3; p++) begin
            hi = 16'(chs[p]) << 12;
            push(hi | 16'h0000, 1, 0, 0, chs[p], 0);
            push(hi | 16'h0001, 0, 0, 0, chs[p], 0);
            push(hi | 16'h0002, 0, 0, 0, chs[p], 0);
            push(hi | 16'h0003, 0, 1, 0, chs[p], 1);
        end
        for (int p = 0; p < 3; p++) begin
            hi = 16'(chs[p]) << 12;
            send_beat({hi, hi | 16'h1, hi | 16'h2, hi | 16'h3},
                      1, 1, 0, chs[p]);
        end
        idle_in();
    endtask

    initial begin
        int base;
        arstn_i       = 1'b0;
        ast_data_i    = '0;
        ast_empty_i   = '0;
        ast_channel_i = '0;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        arstn_i = 1'b1;
        @(posedge clk);
        #1;

        push(16'h1111, 1, 0, 0, 3, 0);
        push(16'h2222, 0, 0, 0, 3, 0);
        push(16'h3333, 0, 0, 0, 3, 0);
        push(16'h4444, 0, 1, 0, 3, 1);
        send_beat(64'h1111_2222_3333_4444, 1, 1, 0, 3);
        chk("latency_valid", 64'(ast_valid_o), 64'd1);
        idle_in();
        drain();

        base = xfers;
        pkt2();
        drain();
        chk("partial_words", 64'(xfers - base), 64'd7);

        b2b_en = 1'b1;
        base   = xfers;
        pkt3();
        drain();
        chk("b2b_bubbles", 64'(idle_cnt), 64'd0);
        chk("b2b_words", 64'(xfers - base), 64'd12);
        b2b_en = 1'b0;

        bp_en = 1'b1;
        base  = xfers;
        pkt2();
        pkt3();
        drain();
        chk("bp_words", 64'(xfers - base), 64'd19);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        push(16'hDEAD, 1, 0, 0, 1, 0);
        push(16'hBEEF, 0, 0, 0, 1, 0);
        push(16'hCAFE, 0, 0, 0, 1, 0);
        push(16'hF00D, 0, 1, 0, 1, 1);
        base = xfers;
        send_beat(64'hDEAD_BEEF_CAFE_F00D, 1, 1, 0, 1);
        idle_in();
        for (int t = 0; t < 50 && xfers < base + 2; t++) @(posedge clk);
        @(posedge clk);
        #2;
        arstn_i = 1'b0;
        #1;
        chk_cleared("midreset");
        q.delete();
        @(posedge clk);
        #1;
        arstn_i = 1'b1;
        @(posedge clk);
        #1;
        push(16'h1234, 1, 0, 0, 4, 0);
        push(16'h5678, 0, 0, 0, 4, 0);
        push(16'h9ABC, 0, 1, 0, 4, 1);
        send_beat(64'h1234_5678_9ABC_DEF0, 1, 1, 2, 4);
        idle_in();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
